// File: rtl/rs_status_array.sv
// rs_status_array: per-entry valid/scheduled/replay/operand-ready store for an 8-entry reservation station.
module rs_status_array #(
  parameter int NUM_ENTRY    = 8,
  parameter int NUM_SRC      = 2,
  parameter int PTAG_W       = 7,
  parameter int REPLAY_DELAY = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic [NUM_ENTRY-1:0] io_validVec,
  input  logic                 io_update_valid,
  input  logic [NUM_ENTRY-1:0] io_update_addr,
  input  logic [PTAG_W-1:0]    io_update_psrc_0,
  input  logic [PTAG_W-1:0]    io_update_psrc_1,
  input  logic [NUM_SRC-1:0]   io_update_srcState,
  input  logic                 io_wakeup_0_valid,
  input  logic [PTAG_W-1:0]    io_wakeup_0_bits,
  input  logic                 io_wakeup_1_valid,
  input  logic [PTAG_W-1:0]    io_wakeup_1_bits,
  output logic [NUM_ENTRY-1:0] io_request,
  input  logic                 io_grant_valid,
  input  logic [NUM_ENTRY-1:0] io_grant_bits,
  input  logic                 io_deqResp_valid,
  input  logic [NUM_ENTRY-1:0] io_deqResp_mask,
  input  logic                 io_deqResp_success
);
  logic [NUM_ENTRY-1:0] valid, sched, deq_hit, free, enq_ok, gnt;
  logic [1:0]           credit [NUM_ENTRY];
  logic [NUM_SRC-1:0]   rdy    [NUM_ENTRY];
  logic [NUM_SRC-1:0]   woke   [NUM_ENTRY];
  logic [PTAG_W-1:0]    psrc   [NUM_ENTRY][NUM_SRC];
  logic [PTAG_W-1:0]    upd_psrc [NUM_SRC];
  logic [NUM_SRC-1:0]   byp;
  // Loaded one below the delay so the entry requests exactly REPLAY_DELAY cycles after the failed response is presented.
  localparam logic [1:0] CREDIT_LOAD = 2'(REPLAY_DELAY - 1);
  function automatic logic wake(input logic [PTAG_W-1:0] t);
    return (io_wakeup_0_valid && io_wakeup_0_bits == t) || (io_wakeup_1_valid && io_wakeup_1_bits == t);
  endfunction
  assign upd_psrc[0] = io_update_psrc_0;
  assign upd_psrc[1] = io_update_psrc_1;
  assign io_validVec = valid;
  always_comb begin
    io_request = '0;
    deq_hit = '0;
    free = '0;
    enq_ok = '0;
    gnt = '0;
    byp = '0;
    for (int s = 0; s < NUM_SRC; s++) byp[s] = wake(upd_psrc[s]);
    for (int i = 0; i < NUM_ENTRY; i++) begin
      woke[i] = '0;
      for (int s = 0; s < NUM_SRC; s++) woke[i][s] = wake(psrc[i][s]);
      io_request[i] = valid[i] & ~sched[i] & (credit[i] == 2'd0) & (&rdy[i]);
      deq_hit[i] = io_deqResp_valid & io_deqResp_mask[i] & valid[i];
      free[i] = deq_hit[i] & io_deqResp_success;
      enq_ok[i] = io_update_valid & io_update_addr[i] & (~valid[i] | free[i]);
      gnt[i] = io_grant_valid & io_grant_bits[i] & io_request[i];
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= '0;
      sched <= '0;
      for (int i = 0; i < NUM_ENTRY; i++) begin
        credit[i] <= '0;
        rdy[i] <= '0;
        for (int s = 0; s < NUM_SRC; s++) psrc[i][s] <= '0;
      end
    end else begin
      assert (!io_update_valid || $onehot(io_update_addr));
      assert (!io_grant_valid || $onehot(io_grant_bits));
      assert (!io_deqResp_valid || $onehot(io_deqResp_mask));
      assert (!io_update_valid || !(|(io_update_addr & valid & ~free)));
      for (int i = 0; i < NUM_ENTRY; i++) begin
        if (enq_ok[i]) begin
          valid[i] <= 1'b1;
          sched[i] <= 1'b0;
          credit[i] <= '0;
          rdy[i] <= io_update_srcState | byp;
          for (int s = 0; s < NUM_SRC; s++) psrc[i][s] <= upd_psrc[s];
        end else if (deq_hit[i]) begin
          valid[i] <= ~io_deqResp_success;
          sched[i] <= 1'b0;
          credit[i] <= io_deqResp_success ? 2'd0 : CREDIT_LOAD;
          rdy[i] <= rdy[i] | woke[i];
        end else if (valid[i]) begin
          sched[i] <= sched[i] | gnt[i];
          credit[i] <= credit[i] - 2'(credit[i] != 2'd0);
          rdy[i] <= rdy[i] | woke[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_rs_status_array.sv
// tb_rs_status_array: directed plan plus random legal traffic against a cycle-count reference model.
module tb_rs_status_array;
  logic       clock = 1'b0, reset;
  logic [7:0] io_validVec, io_request;
  logic       uv, w0v, w1v, gv, dv, ds;
  logic [7:0] ua, gb, dm;
  logic [6:0] p0, p1, w0b, w1b;
  logic [1:0] ss;
  int total = 0, bad = 0, cyc = 0;
  bit         mv [8], ms [8];
  bit         mr [8][2];
  logic [6:0] mt [8][2];
  int         ready_at [8];
  always #5 clock = ~clock;
  rs_status_array dut (
    .clock(clock), .reset(reset), .io_validVec(io_validVec),
    .io_update_valid(uv), .io_update_addr(ua), .io_update_psrc_0(p0), .io_update_psrc_1(p1),
    .io_update_srcState(ss), .io_wakeup_0_valid(w0v), .io_wakeup_0_bits(w0b),
    .io_wakeup_1_valid(w1v), .io_wakeup_1_bits(w1b), .io_request(io_request),
    .io_grant_valid(gv), .io_grant_bits(gb), .io_deqResp_valid(dv),
    .io_deqResp_mask(dm), .io_deqResp_success(ds)
  );
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  function automatic bit hit(input logic [6:0] t);
    return (w0v && w0b == t) || (w1v && w1b == t);
  endfunction
  function automatic logic [7:0] m_req();
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = mv[i] && !ms[i] && cyc >= ready_at[i] && mr[i][0] && mr[i][1];
    return r;
  endfunction
  function automatic logic [7:0] m_vv();
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = mv[i];
    return r;
  endfunction
  task automatic idle();
    reset = 0; uv = 0; ua = 0; p0 = 0; p1 = 0; ss = 0; w0v = 0; w0b = 0; w1v = 0; w1b = 0;
    gv = 0; gb = 0; dv = 0; dm = 0; ds = 0;
  endtask
  task automatic step();
    logic [7:0] rq;
    bit deq, fr, enq;
    rq = m_req();
    for (int i = 0; i < 8; i++) begin
      deq = dv && dm[i] && mv[i];
      fr = deq && ds;
      enq = uv && ua[i] && (!mv[i] || fr);
      if (reset) begin
        mv[i] = 0; ms[i] = 0; ready_at[i] = 0; mr[i][0] = 0; mr[i][1] = 0;
      end else if (enq) begin
        mv[i] = 1; ms[i] = 0; ready_at[i] = 0;
        mt[i][0] = p0; mt[i][1] = p1;
        mr[i][0] = ss[0] || hit(p0); mr[i][1] = ss[1] || hit(p1);
      end else if (deq || mv[i]) begin
        if (deq && ds) mv[i] = 0;
        if (deq) begin
          ms[i] = 0;
          if (!ds) ready_at[i] = cyc + 3;
        end else if (gv && gb[i] && rq[i]) ms[i] = 1;
        for (int s = 0; s < 2; s++) if (hit(mt[i][s])) mr[i][s] = 1;
      end
    end
    cyc++;
    @(posedge clock);
    #1;
    chk("validVec", io_validVec, m_vv());
    chk("request", io_request, m_req());
  endtask
  task automatic enq(input int e, input logic [6:0] a, input logic [6:0] b, input logic [1:0] st);
    idle(); uv = 1; ua = 8'(1 << e); p0 = a; p1 = b; ss = st;
    step();
  endtask
  task automatic grant(input logic [7:0] m);
    idle(); gv = 1; gb = m;
    step();
  endtask
  task automatic deq(input logic [7:0] m, input logic ok);
    idle(); dv = 1; dm = m; ds = ok;
    step();
  endtask
  initial begin
    idle();
    reset = 1; uv = 1; ua = 8'h01; ss = 2'b11; gv = 1; gb = 8'h01;
    step(); step();
    idle(); step();
    chk("reset_vv", io_validVec, 8'h00);
    chk("reset_req", io_request, 8'h00);
    enq(0, 7'd1, 7'd2, 2'b11);
    chk("enq0_vv", io_validVec, 8'h01);
    chk("enq0_req", io_request, 8'h01);
    grant(8'h01);
    chk("grant0_req", io_request, 8'h00);
    idle(); step();
    deq(8'h01, 1);
    chk("free0_vv", io_validVec, 8'h00);
    enq(2, 7'd5, 7'd9, 2'b10);
    chk("wait_src", io_request, 8'h00);
    idle(); step();
    idle(); w1v = 1; w1b = 7'd5; step();
    chk("wakeup1", io_request, 8'h04);
    grant(8'h04); deq(8'h04, 1);
    idle(); uv = 1; ua = 8'h04; p0 = 7'd5; p1 = 7'd9; ss = 2'b10; w0v = 1; w0b = 7'd5; step();
    chk("bypass", io_request, 8'h04);
    grant(8'h04); deq(8'h04, 1);
    enq(3, 7'd20, 7'd21, 2'b11);
    grant(8'h08);
    deq(8'h08, 0);
    chk("replay_t1", io_request, 8'h00);
    idle(); step();
    chk("replay_t2", io_request, 8'h00);
    idle(); step();
    chk("replay_t3", io_request, 8'h08);
    grant(8'h08); deq(8'h08, 1);
    enq(1, 7'd10, 7'd11, 2'b11);
    enq(4, 7'd12, 7'd13, 2'b11);
    idle(); dv = 1; dm = 8'h02; ds = 1; uv = 1; ua = 8'h02; p0 = 7'd33; p1 = 7'd44; ss = 2'b00; step();
    chk("swap_vv", io_validVec, 8'h12);
    chk("swap_req", io_request, 8'h10);
    idle(); w0v = 1; w0b = 7'd10; w1v = 1; w1b = 7'd11; step();
    chk("old_tags", io_request, 8'h10);
    idle(); w0v = 1; w0b = 7'd33; w1v = 1; w1b = 7'd44; step();
    chk("new_tags", io_request, 8'h12);
    grant(8'h02); deq(8'h02, 1); grant(8'h10); deq(8'h10, 1);
    for (int e = 0; e < 8; e++) enq(e, 7'(e), 7'(e + 8), 2'b11);
    chk("full_vv", io_validVec, 8'hff);
    chk("full_req", io_request, 8'hff);
    grant(8'h80);
    chk("grant7", io_request, 8'h7f);
    idle(); gb = 8'h40; step();
    chk("grant_inval", io_request, 8'h7f);
    idle(); reset = 1; step();
    chk("midreset_vv", io_validVec, 8'h00);
    chk("midreset_req", io_request, 8'h00);
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] cand, rq;
      int k;
      idle();
      reset = ($urandom_range(199) == 0);
      if ($urandom_range(2) == 0) begin
        dv = 1; dm = 8'(1 << $urandom_range(7)); ds = 1'($urandom);
      end
      for (int i = 0; i < 8; i++) cand[i] = !mv[i] || (dv && dm[i] && ds);
      if (cand != 0 && $urandom_range(1) == 0) begin
        do k = $urandom_range(7); while (!cand[k]);
        uv = 1; ua = 8'(1 << k); p0 = 7'($urandom_range(15)); p1 = 7'($urandom_range(15)); ss = 2'($urandom);
      end
      rq = m_req();
      if ($urandom_range(1) == 0) begin
        gv = 1;
        if (rq != 0 && $urandom_range(3) != 0) begin
          do k = $urandom_range(7); while (!rq[k]);
        end else k = $urandom_range(7);
        gb = 8'(1 << k);
      end
      w0v = 1'($urandom); w0b = 7'($urandom_range(15));
      w1v = 1'($urandom); w1b = 7'($urandom_range(15));
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
